// File: rtl/serial_borrow_subtractor_pkg.sv
// serial_borrow_subtractor_pkg: shared state encoding, flag positions and counter sizing
package serial_borrow_subtractor_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    localparam int FLAG_B = 0;
    localparam int FLAG_V = 1;
    localparam int FLAG_Z = 2;
    localparam int FLAG_N = 3;

    function automatic int cnt_w(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/full_subtractor_1bit.sv
// full_subtractor_1bit: one ripple-borrow stage, d = a - b - bw_in
module full_subtractor_1bit (
    input  logic a,
    input  logic b,
    input  logic bw_in,
    output logic d,
    output logic bw_out
);

    assign d      = a ^ b ^ bw_in;
    assign bw_out = (~a & b) | (~(a ^ b) & bw_in);

endmodule

// File: rtl/serial_borrow_subtractor.sv
// serial_borrow_subtractor: bit-serial A - B, one borrow stage per clock, start/done handshake
module serial_borrow_subtractor
    import serial_borrow_subtractor_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Result,
    output logic             b_out,
    output logic             v_flag,
    output logic             z_flag
);

    localparam int CNT_W = cnt_w(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_sh, b_sh, r_nxt;
    logic [WIDTH-2:0] r_sh;
    logic [CNT_W-1:0] cnt;
    logic [FLAG_N-1:0] flags;
    logic             bw, bw_nxt, d, last, accept;

    full_subtractor_1bit u_fs (
        .a     (a_sh[0]),
        .b     (b_sh[0]),
        .bw_in (bw),
        .d     (d),
        .bw_out(bw_nxt)
    );

    // Next state, handshake outputs and the partial result with the current bit merged on top
    always_comb begin
        last      = (state == RUN) && (cnt == LAST);
        accept    = start && (state != RUN);
        state_nxt = (state == RUN) ? (last ? DONE : RUN) : (accept ? RUN : IDLE);
        busy      = state == RUN;
        done      = state == DONE;
        r_nxt     = {d, r_sh};
    end

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // Operand/result shifting one bit per RUN cycle; outputs only load on the final bit
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            a_sh   <= '0;
            b_sh   <= '0;
            r_sh   <= '0;
            bw     <= 1'b0;
            cnt    <= '0;
            Result <= '0;
            flags  <= '0;
        end else if (accept) begin
            a_sh <= A;
            b_sh <= B;
            r_sh <= '0;
            bw   <= 1'b0;
            cnt  <= '0;
        end else if (busy) begin
            a_sh <= {1'b0, a_sh[WIDTH-1:1]};
            b_sh <= {1'b0, b_sh[WIDTH-1:1]};
            r_sh <= r_nxt[WIDTH-1:1];
            bw   <= bw_nxt;
            cnt  <= cnt + CNT_W'(1);
            if (last) begin
                Result        <= r_nxt;
                flags[FLAG_B] <= bw_nxt;
                flags[FLAG_V] <= (a_sh[0] ^ b_sh[0]) & (a_sh[0] ^ d);
                flags[FLAG_Z] <= ~|r_nxt;
            end
        end
    end

    assign b_out  = flags[FLAG_B];
    assign v_flag = flags[FLAG_V];
    assign z_flag = flags[FLAG_Z];

endmodule

// File: tb/tb_serial_borrow_subtractor.sv
// tb_serial_borrow_subtractor: scoreboard bench for WIDTH=4 and WIDTH=32 instances
module tb_serial_borrow_subtractor;

    typedef struct packed {
        logic [31:0] r;
        logic        bo;
        logic        v;
        logic        z;
        int          due;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start4 = 1'b0, start32 = 1'b0;
    logic [3:0]  a4 = '0, b4 = '0;
    logic [31:0] a32 = '0, b32 = '0;
    logic        busy4, done4, bo4, v4, z4;
    logic        busy32, done32, bo32, v32, z32;
    logic [3:0]  r4;
    logic [31:0] r32;

    int          cyc = 0;
    int          n_cmp = 0, n_err = 0;
    exp_t        q4[$], q32[$];
    logic        mon_en = 1'b0, active = 1'b0;
    int          acc = 0;
    logic [3:0]  last_r = '0;

    serial_borrow_subtractor #(.WIDTH(4)) u4 (
        .clock(clk), .reset_n(reset_n), .start(start4), .A(a4), .B(b4),
        .busy(busy4), .done(done4), .Result(r4), .b_out(bo4), .v_flag(v4), .z_flag(z4)
    );

    serial_borrow_subtractor #(.WIDTH(32)) u32 (
        .clock(clk), .reset_n(reset_n), .start(start32), .A(a32), .B(b32),
        .busy(busy32), .done(done32), .Result(r32), .b_out(bo32), .v_flag(v32), .z_flag(z32)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic exp_t model(input int w, input logic [31:0] a, input logic [31:0] b, input int due);
        exp_t        e;
        logic [31:0] m, am, bm;
        m     = (w == 32) ? 32'hffff_ffff : ((32'd1 << w) - 32'd1);
        am    = a & m;
        bm    = b & m;
        e.r   = (am - bm) & m;
        e.bo  = am < bm;
        e.v   = (am[w-1] ^ bm[w-1]) & (am[w-1] ^ e.r[w-1]);
        e.z   = e.r == 32'd0;
        e.due = due;
        return e;
    endfunction

    // WIDTH=4 monitor: done timing, results, busy and result hold
    always @(negedge clk) begin
        if (mon_en) begin
            check("busy4", busy4, active && (cyc - acc) < 4);
            if (done4) begin
                if (q4.size() == 0) begin
                    check("spurious_done4", done4, 1'b0);
                end else begin
                    exp_t e;
                    e = q4.pop_front();
                    check("due4", cyc, e.due);
                    check("result4", r4, e.r);
                    check("bout4", bo4, e.bo);
                    check("v4", v4, e.v);
                    check("z4", z4, e.z);
                    last_r = e.r[3:0];
                end
            end else begin
                check("hold4", r4, last_r);
            end
        end
    end

    // WIDTH=32 monitor
    always @(negedge clk) begin
        if (mon_en && done32) begin
            if (q32.size() == 0) begin
                check("spurious_done32", done32, 1'b0);
            end else begin
                exp_t e;
                e = q32.pop_front();
                check("due32", cyc, e.due);
                check("result32", r32, e.r);
                check("bout32", bo32, e.bo);
                check("v32", v32, e.v);
                check("z32", z32, e.z);
            end
        end
    end

    task automatic launch4(input logic [3:0] a, input logic [3:0] b);
        start4 = 1'b1;
        a4 = a;
        b4 = b;
        @(posedge clk);
        #1;
        q4.push_back(model(4, {28'd0, a}, {28'd0, b}, cyc + 4));
        acc = cyc;
        active = 1'b1;
        start4 = 1'b0;
        a4 = 4'($urandom);
        b4 = 4'($urandom);
    endtask

    task automatic op4(input logic [3:0] a, input logic [3:0] b);
        launch4(a, b);
        repeat (6) @(posedge clk);
        #1;
    endtask

    initial begin
        #12;
        check("rst_busy", busy4, 1'b0);
        check("rst_done", done4, 1'b0);
        check("rst_result", r4, 4'd0);
        check("rst_flags", {bo4, v4, z4}, 3'b000);
        check("rst_result32", r32, 32'd0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        mon_en = 1'b1;

        op4(4'd7, 4'd3);
        op4(4'd3, 4'd7);
        op4(4'd8, 4'd1);
        op4(4'd5, 4'd5);

        launch4(4'd6, 4'd2);
        @(posedge clk);
        #1;
        start4 = 1'b1;
        a4 = 4'd1;
        b4 = 4'd1;
        @(posedge clk);
        #1;
        start4 = 1'b0;
        repeat (5) @(posedge clk);
        #1;

        launch4(4'd9, 4'd4);
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        q4.delete();
        active = 1'b0;
        last_r = '0;
        #1;
        check("abort_busy", busy4, 1'b0);
        check("abort_done", done4, 1'b0);
        check("abort_result", r4, 4'd0);
        check("abort_flags", {bo4, v4, z4}, 3'b000);
        repeat (2) @(posedge clk);
        #2;
        reset_n = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        op4(4'd12, 4'd5);

        start4 = 1'b1;
        a4 = 4'd2;
        b4 = 4'd1;
        @(posedge clk);
        #1;
        q4.push_back(model(4, 32'd2, 32'd1, cyc + 4));
        acc = cyc;
        active = 1'b1;
        a4 = 4'd0;
        b4 = 4'd1;
        repeat (5) @(posedge clk);
        #1;
        q4.push_back(model(4, 32'd0, 32'd1, cyc + 4));
        acc = cyc;
        start4 = 1'b0;
        repeat (7) @(posedge clk);
        #1;

        for (int i = 0; i < 6; i++) op4(4'($urandom), 4'($urandom));

        start32 = 1'b1;
        a32 = 32'd7;
        b32 = 32'd3;
        @(posedge clk);
        #1;
        q32.push_back(model(32, 32'd7, 32'd3, cyc + 32));
        start32 = 1'b0;
        a32 = $urandom;
        repeat (34) @(posedge clk);
        #1;
        start32 = 1'b1;
        a32 = 32'h8000_0000;
        b32 = 32'd1;
        @(posedge clk);
        #1;
        q32.push_back(model(32, 32'h8000_0000, 32'd1, cyc + 32));
        start32 = 1'b0;
        repeat (34) @(posedge clk);
        #1;

        check("q4_drained", q4.size(), 0);
        check("q32_drained", q32.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
